pipe_addsub: RTL

- Parametrised, pipelined N-bit adder/subtractor built from per-bit sum/carry logic. It is the multi-bit successor to the single-bit full adder.
- The operand is split into STAGES equal chunks. Each pipeline stage resolves one chunk, LSB chunk first, and passes the carry to the next stage through a register.
- Valid/ready handshake on input and output; carries ADC/SBC semantics and NZCV-style flags. It sits as an ALU-side arithmetic unit in the PipelineCPU execute path.

---
 rtl/pipe_addsub.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor (ADC/SBC) with NZCV-style flags.
// Each stage resolves one CHUNK of bits, LSB chunk first; carries travel between stages in registers.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             z,
  output logic             n
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Ripple one chunk bit by bit; returns {carry_out, carry_into_msb, sum}.
  function automatic logic [CHUNK+1:0] chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             cin
  );
    logic [CHUNK-1:0] sum;
    logic             c;
    logic             c_msb;
    sum   = '0;
    c     = cin;
    c_msb = cin;
    for (int j = 0; j < CHUNK; j++) begin
      c_msb  = c;
      sum[j] = x[j] ^ y[j] ^ c;
      c      = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
    end
    return {c, c_msb, sum};
  endfunction

  logic [STAGES-1:0] valid_reg, valid_next;
  logic [STAGES-1:0] carry_reg, carry_next;
  logic [STAGES-1:0] zero_reg, zero_next;
  logic [STAGES-1:0] ov_reg, ov_next;
  logic [WIDTH-1:0]  sum_reg   [STAGES];
  logic [WIDTH-1:0]  sum_next  [STAGES];
  // Unresolved operand bits, shifted down so each stage consumes the low CHUNK.
  logic [WIDTH-1:0]  a_rem_reg [STAGES];
  logic [WIDTH-1:0]  a_rem_next[STAGES];
  logic [WIDTH-1:0]  b_rem_reg [STAGES];
  logic [WIDTH-1:0]  b_rem_next[STAGES];
  logic [WIDTH-1:0]  b_eff;
  logic              adv;

  assign adv      = !valid_reg[LAST] || out_ready;
  assign in_ready = adv;

  always_comb begin
    logic [CHUNK+1:0] r;
    b_eff = sub ? ~b : b;

    r             = chunk_add(a[CHUNK-1:0], b_eff[CHUNK-1:0], ci);
    sum_next[0]   = '0;
    sum_next[0][CHUNK-1:0] = r[CHUNK-1:0];
    carry_next[0] = r[CHUNK+1];
    ov_next[0]    = r[CHUNK+1] ^ r[CHUNK];
    zero_next[0]  = (r[CHUNK-1:0] == '0);
    a_rem_next[0] = a >> CHUNK;
    b_rem_next[0] = b_eff >> CHUNK;
    valid_next[0] = in_valid;

    for (int k = 1; k < STAGES; k++) begin
      r             = chunk_add(a_rem_reg[k-1][CHUNK-1:0], b_rem_reg[k-1][CHUNK-1:0],
                                carry_reg[k-1]);
      sum_next[k]   = sum_reg[k-1];
      sum_next[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
      carry_next[k] = r[CHUNK+1];
      ov_next[k]    = r[CHUNK+1] ^ r[CHUNK];
      zero_next[k]  = zero_reg[k-1] & (r[CHUNK-1:0] == '0);
      a_rem_next[k] = a_rem_reg[k-1] >> CHUNK;
      b_rem_next[k] = b_rem_reg[k-1] >> CHUNK;
      valid_next[k] = valid_reg[k-1];
    end
  end

  // Payload only loads behind a valid bit, so bubbles leave the last flags untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      carry_reg <= '0;
      zero_reg  <= '0;
      ov_reg    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_reg[k]   <= '0;
        a_rem_reg[k] <= '0;
        b_rem_reg[k] <= '0;
      end
    end else if (adv) begin
      valid_reg <= valid_next;
      for (int k = 0; k < STAGES; k++) begin
        if (valid_next[k]) begin
          sum_reg[k]   <= sum_next[k];
          carry_reg[k] <= carry_next[k];
          zero_reg[k]  <= zero_next[k];
          ov_reg[k]    <= ov_next[k];
          a_rem_reg[k] <= a_rem_next[k];
          b_rem_reg[k] <= b_rem_next[k];
        end
      end
    end
  end

  assign out_valid = valid_reg[LAST];
  assign s         = sum_reg[LAST];
  assign co        = carry_reg[LAST];
  assign ov        = ov_reg[LAST];
  assign z         = zero_reg[LAST];
  assign n         = sum_reg[LAST][WIDTH-1];

endmodule
